// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 receive controller.
//   - receive FSM state encoding (IDLE=0, DATA=1, PARITY=2, STOP=3)
//   - scan-code prefix bytes (E0 = extended, F0 = break/release)
//   - bit counter width and an odd-parity helper
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
  localparam int         PS2_BIT_CNT_W  = 4;

  // PS/2 uses odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_rx_controller_if.sv
// ps2_rx_controller_if: pin-side inputs and decoded-key outputs of the PS/2 receiver.
//   ps2_clk, ps2_dat : raw PS/2 lines (inputs to the receiver)
//   key_code[7:0]    : last decoded scan code (held between events)
//   key_ext          : code was preceded by E0
//   key_break        : code was preceded by F0
//   key_valid        : one-cycle pulse when a new key event is presented
//   frame_err        : one-cycle pulse on parity, stop-bit or timeout error
//   busy             : receiver is inside a frame
// Modports: master = the receiver, slave = the pins/consumer side.
interface ps2_rx_controller_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_valid;
  logic       frame_err;
  logic       busy;

  modport master (
    input  ps2_clk, ps2_dat,
    output key_code, key_ext, key_break, key_valid, frame_err, busy
  );

  modport slave (
    output ps2_clk, ps2_dat,
    input  key_code, key_ext, key_break, key_valid, frame_err, busy
  );
endinterface

// File: rtl/ps2_input_filter.sv
// ps2_input_filter: conditions the raw PS/2 lines.
//   clk, reset       : system clock, asynchronous active-high reset
//   ps2_clk, ps2_dat : raw PS/2 lines
//   dat_s            : synchronized data line
//   fall             : one-cycle pulse when the deglitched PS/2 clock goes 1->0
// Both lines get a 2-flop synchronizer. The PS/2 clock level is only accepted
// after FILTER_LEN consecutive synchronized samples that differ from the
// current filtered level; any sample back at the old level restarts the count.
module ps2_input_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic dat_s,
  output logic fall
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  // index 0 = clock line, index 1 = data line
  logic [1:0] raw_in;
  logic [1:0] sync_out;

  assign raw_in = {ps2_dat, ps2_clk};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      logic [1:0] sync_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync_reg <= 2'b11;
        end else begin
          sync_reg <= {sync_reg[0], raw_in[gi]};
        end
      end
      assign sync_out[gi] = sync_reg[1];
    end
  endgenerate

  logic             clk_s;
  logic [CNT_W-1:0] cnt_reg;
  logic             filt_reg;
  logic             fall_reg;
  logic             change_ok;

  assign clk_s     = sync_out[0];
  // This sample is the FILTER_LEN-th in a row at the new level.
  assign change_ok = (clk_s != filt_reg) && (cnt_reg == CNT_W'(FILTER_LEN - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg  <= '0;
      filt_reg <= 1'b1;
      fall_reg <= 1'b0;
    end else begin
      fall_reg <= 1'b0;
      if (clk_s == filt_reg) begin
        cnt_reg <= '0;
      end else if (change_ok) begin
        cnt_reg  <= '0;
        filt_reg <= clk_s;
        fall_reg <= filt_reg;   // only a 1->0 change produces a pulse
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign dat_s = sync_out[1];
  assign fall  = fall_reg;

endmodule

// File: rtl/ps2_rx_controller.sv
// ps2_rx_controller: receives PS/2 keyboard frames (start, 8 data LSB first,
// odd parity, stop) and turns scan codes with E0/F0 prefixes into key events.
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : ps2_rx_controller_if.master (raw PS/2 pins in, key event outputs)
// Optional build macro PS2_TIMEOUT_EN: adds a frame timeout counter that
// aborts a frame (frame_err pulse, prefixes cleared) when no PS/2 clock fall
// arrives for TIMEOUT_CYCLES-1 cycles while a frame is in progress. Without
// it a stalled frame simply waits for further falls.
module ps2_rx_controller
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int TIMEOUT_US  = 2000,
  parameter int FILTER_LEN  = 8
) (
  input logic                  clk,
  input logic                  reset,
  ps2_rx_controller_if.master  bus
);

  logic dat_s;
  logic fall;

  ps2_input_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk     (clk),
    .reset   (reset),
    .ps2_clk (bus.ps2_clk),
    .ps2_dat (bus.ps2_dat),
    .dat_s   (dat_s),
    .fall    (fall)
  );

  ps2_state_e               state_reg, state_next;
  logic [PS2_BIT_CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0]               shift_reg, shift_next;
  logic                     parity_reg, parity_next;
  logic                     byte_ok;
  logic                     byte_bad;
  logic                     timeout_hit;

`ifdef PS2_TIMEOUT_EN
  localparam int TIMEOUT_CYCLES = CLK_FREQ_HZ / 1000000 * TIMEOUT_US;
  localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_reg <= '0;
    end else if (fall || state_reg == IDLE || timeout_hit) begin
      to_cnt_reg <= '0;
    end else begin
      to_cnt_reg <= to_cnt_reg + 1'b1;
    end
  end

  // A fall in the same cycle wins over the timeout.
  assign timeout_hit = (state_reg != IDLE) && !fall &&
                       (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Frame sequencing: next state plus the end-of-frame verdict.
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    parity_next  = parity_reg;
    byte_ok      = 1'b0;
    byte_bad     = 1'b0;

    if (timeout_hit) begin
      state_next = IDLE;
    end else if (fall) begin
      case (state_reg)
        IDLE: begin
          // A fall with data high is not a start bit; ignore it silently.
          if (!dat_s) begin
            state_next   = DATA;
            bit_cnt_next = '0;
          end
        end
        DATA: begin
          shift_next   = {dat_s, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == PS2_BIT_CNT_W'(7)) begin
            state_next = PARITY;
          end
        end
        PARITY: begin
          parity_next = dat_s;
          state_next  = STOP;
        end
        STOP: begin
          state_next = IDLE;
          if (odd_parity_ok(shift_reg, parity_reg) && dat_s) begin
            byte_ok = 1'b1;
          end else begin
            byte_bad = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      parity_reg  <= parity_next;
    end
  end

  // Prefix decoder. It is registered from the stop-bit cycle, so events
  // appear exactly one clock after the stop-bit fall.
  logic       ext_reg;
  logic       brk_reg;
  logic [7:0] key_code_reg;
  logic       key_ext_reg;
  logic       key_break_reg;
  logic       key_valid_reg;
  logic       frame_err_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_reg       <= 1'b0;
      brk_reg       <= 1'b0;
      key_code_reg  <= '0;
      key_ext_reg   <= 1'b0;
      key_break_reg <= 1'b0;
      key_valid_reg <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      key_valid_reg <= 1'b0;
      frame_err_reg <= 1'b0;
      if (byte_bad || timeout_hit) begin
        // A broken frame may have been the real key code; drop any pending prefix.
        frame_err_reg <= 1'b1;
        ext_reg       <= 1'b0;
        brk_reg       <= 1'b0;
      end else if (byte_ok) begin
        if (shift_reg == PS2_EXT_PREFIX) begin
          ext_reg <= 1'b1;
        end else if (shift_reg == PS2_BRK_PREFIX) begin
          brk_reg <= 1'b1;
        end else begin
          key_code_reg  <= shift_reg;
          key_ext_reg   <= ext_reg;
          key_break_reg <= brk_reg;
          key_valid_reg <= 1'b1;
          ext_reg       <= 1'b0;
          brk_reg       <= 1'b0;
        end
      end
    end
  end

  assign bus.key_code  = key_code_reg;
  assign bus.key_ext   = key_ext_reg;
  assign bus.key_break = key_break_reg;
  assign bus.key_valid = key_valid_reg;
  assign bus.frame_err = frame_err_reg;
  assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_ps2_rx_controller.sv
// tb_ps2_rx_controller: directed frames into ps2_rx_controller; expected key
// events and frame errors are queued by the stimulus and consumed by a
// monitor whenever key_valid or frame_err is seen.
module tb_ps2_rx_controller;

  localparam int HALF    = 20;   // PS/2 half bit period in system clocks
  localparam int TO_CYC  = 50 * 20;

  logic clk;
  logic reset;

  ps2_rx_controller_if bus ();

  ps2_rx_controller #(
    .CLK_FREQ_HZ (50000000),
    .TIMEOUT_US  (20),
    .FILTER_LEN  (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] code;
    bit         ext;
    bit         brk;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic expect_key(input logic [7:0] code, input bit ext, input bit brk);
    exp_t e;
    e.is_err = 1'b0; e.code = code; e.ext = ext; e.brk = brk;
    exp_q.push_back(e);
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1; e.code = 8'h00; e.ext = 1'b0; e.brk = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.ps2_dat = b;
    tick(HALF);
    bus.ps2_clk = 1'b0;
    tick(HALF);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input string name, input logic [7:0] data,
                            input logic par, input logic stp);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    send_bit(par);
    send_bit(stp);
    bus.ps2_dat = 1'b1;
    tick(HALF);
    check({name, " drained"}, exp_q.size(), 0);
  endtask

  // Monitor: one line per observed transaction.
  always @(negedge clk) begin
    if (!reset && (bus.key_valid || bus.frame_err)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected event: valid=%0b err=%0b code=%0h, none expected",
                 bus.key_valid, bus.frame_err, bus.key_code);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.is_err) begin
          if (!bus.frame_err || bus.key_valid) begin
            n_fail++;
            $display("FAIL err event: valid=%0b err=%0b, required err only",
                     bus.key_valid, bus.frame_err);
          end else begin
            $display("txn frame_err");
          end
        end else if (!bus.key_valid || bus.frame_err || bus.key_code !== e.code ||
                     bus.key_ext !== e.ext || bus.key_break !== e.brk) begin
          n_fail++;
          $display("FAIL key event: valid=%0b err=%0b code=%0h ext=%0b brk=%0b, required code=%0h ext=%0b brk=%0b",
                   bus.key_valid, bus.frame_err, bus.key_code, bus.key_ext, bus.key_break,
                   e.code, e.ext, e.brk);
        end else begin
          $display("txn key code=%0h ext=%0b brk=%0b", bus.key_code, bus.key_ext, bus.key_break);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit busy_seen;
    reset       = 1'b1;
    bus.ps2_clk = 1'b1;
    bus.ps2_dat = 1'b1;
    tick(3);
    check("reset outputs", {bus.key_code, bus.key_ext, bus.key_break,
                            bus.key_valid, bus.frame_err, bus.busy}, 0);
    reset = 1'b0;
    tick(5);

    // Plain make code
    expect_key(8'h1C, 1'b0, 1'b0);
    send_frame("1C", 8'h1C, 1'b0, 1'b1);

    // Break of 1C
    send_frame("F0", 8'hF0, 1'b1, 1'b1);
    expect_key(8'h1C, 1'b0, 1'b1);
    send_frame("F0 1C", 8'h1C, 1'b0, 1'b1);
    tick(10);
    check("key_code hold", {bus.key_code, bus.key_break}, {8'h1C, 1'b1});

    // Extended break, then flags cleared
    send_frame("E0", 8'hE0, 1'b0, 1'b1);
    send_frame("E0 F0", 8'hF0, 1'b1, 1'b1);
    expect_key(8'h75, 1'b1, 1'b1);
    send_frame("E0 F0 75", 8'h75, 1'b0, 1'b1);
    expect_key(8'h1C, 1'b0, 1'b0);
    send_frame("1C after ext", 8'h1C, 1'b0, 1'b1);

    // Parity error
    expect_err();
    send_frame("bad parity", 8'h1C, 1'b1, 1'b1);
    expect_key(8'h1C, 1'b0, 1'b0);
    send_frame("1C after parity err", 8'h1C, 1'b0, 1'b1);

    // Stop-bit error
    expect_err();
    send_frame("bad stop", 8'h1C, 1'b0, 1'b0);

    // An error frame discards a pending E0
    send_frame("E0 before err", 8'hE0, 1'b0, 1'b1);
    expect_err();
    send_frame("bad parity 2", 8'h75, 1'b1, 1'b1);
    expect_key(8'h75, 1'b0, 1'b0);
    send_frame("75 after err", 8'h75, 1'b0, 1'b1);

    // Short glitch on the clock line in IDLE
    busy_seen = 1'b0;
    bus.ps2_clk = 1'b0;
    tick(3);
    bus.ps2_clk = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (bus.busy) busy_seen = 1'b1;
    end
    check("glitch busy", busy_seen, 0);

    // Reset mid-DATA
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    check("busy mid frame", bus.busy, 1);
    #3 reset = 1'b1;
    #2;
    check("async reset outputs", {bus.key_code, bus.key_ext, bus.key_break,
                                  bus.key_valid, bus.frame_err, bus.busy}, 0);
    tick(3);
    reset = 1'b0;
    tick(5);
    check("busy after reset", bus.busy, 0);
    expect_key(8'h1C, 1'b0, 1'b0);
    send_frame("1C after reset", 8'h1C, 1'b0, 1'b1);

`ifdef PS2_TIMEOUT_EN
    // Stalled frame: start plus 5 data bits of 1C, then silence
    expect_err();
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    tick(TO_CYC + 10);
    check("timeout busy", bus.busy, 0);
    check("timeout drained", exp_q.size(), 0);
    expect_key(8'h1C, 1'b0, 1'b0);
    send_frame("1C after timeout", 8'h1C, 1'b0, 1'b1);
`endif

    tick(20);
    check("final drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
